pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register for the Cortex-M0 core. It is the generalised replacement for the fixed-field inter-stage latches such as ID/EXE. The stage carries an opaque DATA_W-bit payload under a valid/ready handshake, with synchronous flush for branch redirect. An optional two-entry skid buffer registers the backpressure path. A saturating stall counter supports performance debug.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_sat_counter.sv | 20 ++
 rtl/pipe_stage_reg.sv | 130 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline stages: FSM states, default widths
// and the packed ID/EXE bundle layout used by decode (pack) and execute (unpack).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    localparam int PIPE_DATA_W_DEF = 32;
    localparam int PIPE_CNT_W_DEF  = 16;

    // ID/EXE bundle, LSB first: ALU op, register indices, immediate, control flags.
    localparam int IDEX_ALU_OP_LSB = 0;
    localparam int IDEX_ALU_OP_W   = 4;
    localparam int IDEX_RD_LSB     = IDEX_ALU_OP_LSB + IDEX_ALU_OP_W;
    localparam int IDEX_RD_W       = 4;
    localparam int IDEX_RN_LSB     = IDEX_RD_LSB + IDEX_RD_W;
    localparam int IDEX_RN_W       = 4;
    localparam int IDEX_RM_LSB     = IDEX_RN_LSB + IDEX_RN_W;
    localparam int IDEX_RM_W       = 4;
    localparam int IDEX_IMM_LSB    = IDEX_RM_LSB + IDEX_RM_W;
    localparam int IDEX_IMM_W      = 12;
    localparam int IDEX_FLAGS_LSB  = IDEX_IMM_LSB + IDEX_IMM_W;
    localparam int IDEX_FLAGS_W    = 4;
    localparam int IDEX_BUNDLE_W   = IDEX_FLAGS_LSB + IDEX_FLAGS_W;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; sticks at all-ones until reset.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != CNT_MAX))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with synchronous flush and stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = PIPE_DATA_W_DEF,
    parameter int CNT_W          = PIPE_CNT_W_DEF,
    parameter int CLEAR_ON_FLUSH = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              in_xfer;
    logic              out_xfer;
    logic              vld_q;
    logic [DATA_W-1:0] main_q;

    assign out_valid = vld_q;
    assign out_data  = main_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = vld_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    pipe_state_t       state, state_nx;
    logic [DATA_W-1:0] skid_q;
    logic              rdy_q;
    logic              main_ld, main_from_skid, skid_ld;

    assign in_ready = rdy_q;

    always_comb begin
        state_nx       = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    main_ld  = 1'b1;
                    state_nx = FULL;
                end
            end
            FULL: begin
                if (in_xfer && out_xfer) begin
                    main_ld = 1'b1;
                end else if (out_xfer) begin
                    state_nx = EMPTY;
                end else if (in_xfer) begin
                    skid_ld  = 1'b1;
                    state_nx = SKID;
                end
            end
            SKID: begin
                if (out_xfer) begin
                    main_from_skid = 1'b1;
                    state_nx       = FULL;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // valid/ready are kept as their own flops so both outputs are register-driven
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            vld_q  <= 1'b0;
            rdy_q  <= 1'b1;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            if (CLEAR_ON_FLUSH != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            state <= state_nx;
            vld_q <= (state_nx != EMPTY);
            rdy_q <= (state_nx != SKID);
            if (main_ld)
                main_q <= in_data;
            else if (main_from_skid)
                main_q <= skid_q;
            if (skid_ld)
                skid_q <= in_data;
        end
    end
`else
    // Single entry: a stalled stage frees up in the same cycle downstream accepts.
    assign in_ready = ~vld_q | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            main_q <= '0;
        end else if (flush) begin
            vld_q <= 1'b0;
            if (CLEAR_ON_FLUSH != 0)
                main_q <= '0;
        end else if (in_xfer) begin
            vld_q  <= 1'b1;
            main_q <= in_data;
        end else if (out_xfer) begin
            vld_q <= 1'b0;
        end
    end
`endif

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (vld_q & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue model checked every cycle plus directed literals.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [31:0] a_out_data, b_out_data;
    logic [15:0] a_stall;
    logic [2:0]  b_stall;

    always #5 clk = ~clk;

    pipe_stage_reg u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.DATA_W(32), .CNT_W(3), .CLEAR_ON_FLUSH(1)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall)
    );

    // model: FIFO of held entries; "last" is what the main register shows when empty
    logic [31:0] mq[$];
    logic [31:0] last_a, last_b;
    int          mstall;
    bit          started = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
`ifdef PIPE_STAGE_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || out_ready;
`endif
    endfunction

    function automatic logic [31:0] m_data(input logic [31:0] last);
        return (mq.size() > 0) ? mq[0] : last;
    endfunction

    function automatic logic [31:0] sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_update();
        logic ir;
        ir = m_ready();
        if (rst) begin
            mq.delete();
            last_a = '0;
            last_b = '0;
            mstall = 0;
        end else begin
            if (mq.size() > 0 && !out_ready && mstall < 100000)
                mstall++;
            if (flush) begin
                if (mq.size() > 0)
                    last_a = mq[0];
                last_b = '0;
                mq.delete();
            end else begin
                if (mq.size() > 0 && out_ready) begin
                    last_a = mq.pop_front();
                    last_b = last_a;
                end
                if (in_valid && ir)
                    mq.push_back(in_data);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        started = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("a_in_ready",  {31'd0, a_in_ready},  {31'd0, m_ready()});
            check("b_in_ready",  {31'd0, b_in_ready},  {31'd0, m_ready()});
            check("a_out_valid", {31'd0, a_out_valid}, {31'd0, mq.size() > 0});
            check("b_out_valid", {31'd0, b_out_valid}, {31'd0, mq.size() > 0});
            check("a_out_data",  a_out_data, m_data(last_a));
            check("b_out_data",  b_out_data, m_data(last_b));
            check("a_stall_cnt", {16'd0, a_stall}, sat(mstall, 65535));
            check("b_stall_cnt", {29'd0, b_stall}, sat(mstall, 7));
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        tick(); tick();
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_out_data",  a_out_data, 32'd0);
        check("rst_stall",     {16'd0, a_stall}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1 check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);

        // streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = i;
            tick();
            check("stream_data",  a_out_data, i);
            check("stream_valid", {31'd0, a_out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain", {31'd0, a_out_valid}, 32'd0);

        // backpressure: A then B with out_ready low
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick(); tick(); tick();
        check("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
        check("bp_head",     a_out_data, 32'hA);
        check("bp_stall",    {16'd0, a_stall}, 32'd3);
        out_ready = 1'b1;
        tick();
        check("bp_second", a_out_data, 32'hB);
        in_valid = 1'b0;
        tick();
        check("bp_empty", {31'd0, a_out_valid}, 32'd0);

        // flush with a simultaneous input
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h55; flush = 1'b1;
        tick();
        check("flush_valid",   {31'd0, a_out_valid}, 32'd0);
        check("flush_keep",    a_out_data, 32'h11);
        check("flush_cleared", b_out_data, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush_no55", {31'd0, b_out_valid}, 32'd0);

        // counter saturation on the 3-bit instance
        in_valid = 1'b1; in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("sat_b", {29'd0, b_stall}, 32'd7);
        check("sat_a", {16'd0, a_stall}, 32'd14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat_rst", {29'd0, b_stall}, 32'd0);

        // patterned traffic with a mid-stream flush
        for (int i = 0; i < 48; i++) begin
            in_valid  = (i % 3) != 0;
            out_ready = (i % 5) < 3;
            flush     = (i == 29);
            in_data   = 32'h100 + i;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
